tt_mask_idx_agu: RTL
====================

// Module: tt_mask_idx_agu
// PURPOSE
//  LSU-side consumer of the vector mask/index item stream. Buffers 65-bit items {mask, idx[63:0]} in a
//  small credit-managed FIFO and returns one credit per item it consumes.
//  Expands each vector memop into one address request per element, in element order, with a per-element
//  active bit. Requests go to the memory request pipe over a valid/ready handshake.
// PARAMETERS
//  VLEN    256  vector length in bits; max element count = VLEN
//  DEPTH   2    item FIFO entries; equals the producer's credit count
//  ADDR_W  64   address width
// PORTS
//  i_clk                i   1                  clock
//  i_reset_n            i   1                  sync active-low reset
//  i_start              i   1                  start memop; captures the i_* config below
//  i_base_addr          i   ADDR_W             base address
//  i_stride             i   ADDR_W             byte stride (unit-stride: 1<<eew supplied by control)
//  i_vl                 i   $clog2(VLEN+1)     element count
//  i_is_masked          i   1                  memop is masked
//  i_is_indexed         i   1                  memop is indexed
//  i_mask_idx_valid     i   1                  item push
//  i_mask_idx_item      i   65                 [64]=mask bit (indexed); [63:0]=index, or 64 mask bits (strided)
//  i_mask_idx_last_idx  i   1                  final item of memop
//  o_mask_idx_credit    o   1                  one-cycle pulse per FIFO pop
//  o_req_valid          o   1                  element request valid
//  i_req_ready          i   1                  downstream accepts
//  o_req_addr           o   ADDR_W             element address
//  o_req_elem           o   $clog2(VLEN)       element number
//  o_req_active         o   1                  element enabled by mask
//  o_req_last           o   1                  element vl-1
//  o_busy               o   1                  memop in progress (state != IDLE)
// BEHAVIOUR
//  Reset:
//   - FIFO empty; state IDLE.
//   - All outputs 0.
//  FSM:
//   - IDLE->ISSUE on i_start && i_vl!=0. Latch config; elem=0; addr_acc=base.
//   - i_start with vl=0: ignored, stay IDLE.
//   - i_start outside IDLE: ignored; flagged by assertion.
//   - ISSUE->IDLE on the accepted request with o_req_last=1.
//  Item need (nd):
//   - nd = is_indexed || is_masked.
//   - If nd=0: no items consumed; o_req_active=1 for every element.
//  o_req_valid:
//   - = state==ISSUE && (!nd || FIFO non-empty). Comb from registered state.
//   - First request possible the cycle after i_start.
//   - A push at cycle t is visible at t+1; there is no bypass.
//  Handshake:
//   - o_req_* held stable while valid && !ready.
//   - Advance on valid&&ready only.
//  Strided (indexed=0):
//   - o_req_addr = addr_acc; addr_acc += stride on accept, mod 2^ADDR_W.
//   - Masked: active = head.item[elem%64].
//   - Pop head when elem%64==63 or on the last element.
//  Indexed:
//   - o_req_addr = base + zero-ext index, mod 2^ADDR_W.
//   - active = is_masked ? item[64] : 1.
//   - Pop one item per accepted element.
//  Last element:
//   - o_req_last = (elem == vl-1).
//   - If nd, the head item must carry last_idx; mismatch flagged by assertion.
//  FIFO and credits:
//   - At most one push and one pop per cycle; simultaneous push+pop is allowed when full.
//   - Push when full is a protocol error (assertion); the item is dropped.
//   - o_mask_idx_credit registered: pulses the cycle after each pop.
//  Reset mid-op:
//   - FIFO flushed, state IDLE, no credit pulse.
//   - The producer resets its credits with the same reset.
// CONFIGURATION
//  TT_AGU_SKIP_INACTIVE_EN
//   - Defined: masked-off elements are not presented. They consume one internal cycle with
//     o_req_valid=0, and elem/addr_acc still advance (pops follow the same rules).
//   - If the last element is inactive, the block returns to IDLE without a request. o_req_last is then
//     never seen, so downstream must use o_busy falling.
//   - Undefined: every element is issued, with o_req_active=0 where masked off.
// TESTING
//  T1 unmasked strided: vl=5, base=0x1000, stride=8, ready=1 -> addr 0x1000..0x1020 on 5 cycles;
//     last on elem4; no credits.
//  T2 masked strided: vl=70, item0 mask=0xAAAA..AA, item1 mask=0x3F -> elem0 inactive, elem1 active;
//     credit after elem63 and elem69.
//  T3 indexed masked: vl=3, items {1,0x10},{0,0x20},{1,0x30}+last, base=0x100 -> addr 0x110/0x120/0x130,
//     active 1/0/1, 3 credits.
//  T4 backpressure: ready low 4 cycles mid-op -> outputs stable, no pop/credit until accept.
//  T5 FIFO full (DEPTH=2): push+pop same cycle -> no loss. Start with vl=0 -> stays IDLE, o_busy=0.
//  T6 reset asserted during T3 elem1 -> all outputs 0 next cycle; a fresh memop then runs correctly.

Source files
------------

// File: rtl/tt_mask_idx_agu_if.sv
// Mask/index item stream (producer -> AGU) and element request channel (AGU -> memory pipe).
// master = environment side, slave = the address generator.
interface tt_mask_idx_agu_if #(
  parameter int VLEN   = 256,
  parameter int ADDR_W = 64
);
  localparam int ELEM_W = $clog2(VLEN);

  logic              mask_idx_valid;
  logic [64:0]       mask_idx_item;
  logic              mask_idx_last_idx;
  logic              mask_idx_credit;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ELEM_W-1:0] req_elem;
  logic              req_active;
  logic              req_last;

  modport master (
    output mask_idx_valid, mask_idx_item, mask_idx_last_idx, req_ready,
    input  mask_idx_credit, req_valid, req_addr, req_elem, req_active, req_last
  );
  modport slave (
    input  mask_idx_valid, mask_idx_item, mask_idx_last_idx, req_ready,
    output mask_idx_credit, req_valid, req_addr, req_elem, req_active, req_last
  );
endinterface

// File: rtl/tt_mask_idx_agu.sv
// Vector memop address generator: expands a memop into per-element requests using a credit-managed
// mask/index item FIFO. Optional feature macro: TT_AGU_SKIP_INACTIVE_EN (drop masked-off elements).
module tt_mask_idx_agu #(
  parameter int VLEN   = 256,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 64
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic [ADDR_W-1:0]         i_base_addr,
  input  logic [ADDR_W-1:0]         i_stride,
  input  logic [$clog2(VLEN+1)-1:0] i_vl,
  input  logic                      i_is_masked,
  input  logic                      i_is_indexed,
  output logic                      o_busy,
  tt_mask_idx_agu_if.slave          mi
);
  localparam int VL_W   = $clog2(VLEN+1);
  localparam int ELEM_W = $clog2(VLEN);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH+1);

  typedef enum logic {IDLE, ISSUE} state_e;
  state_e state, state_nxt;

  logic [ADDR_W-1:0] cfg_base, cfg_stride, addr_acc, addr;
  logic [VL_W-1:0]   cfg_vl;
  logic              cfg_msk, cfg_idx;
  logic [ELEM_W-1:0] elem;
  logic [64:0]       fifo_item [DEPTH];
  logic              fifo_last [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [64:0]       head_item;
  logic [63:0]       head_mask;
  logic [5:0]        bit_sel;
  logic              head_last, nd, have, active, elem_last;
  logic              req_vld, step, pop, push, start_ok, credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign start_ok = (state == IDLE) && i_start && (i_vl != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = ISSUE;
      ISSUE:   if (step && elem_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    head_item = fifo_item[rd_ptr];
    head_last = fifo_last[rd_ptr];
    head_mask = head_item[63:0];
    bit_sel   = 6'(elem);
    nd        = cfg_idx | cfg_msk;
    have      = !nd || (count != '0);
    elem_last = (VL_W'(elem) == cfg_vl - VL_W'(1));
    if (!nd)          active = 1'b1;
    else if (cfg_idx) active = !cfg_msk || head_item[64];
    else              active = head_mask[bit_sel];
    addr = cfg_idx ? cfg_base + ADDR_W'(head_item[63:0]) : addr_acc;
`ifdef TT_AGU_SKIP_INACTIVE_EN
    // Inactive elements burn one cycle internally without reaching the request pipe.
    req_vld = (state == ISSUE) && have && active;
    step    = (state == ISSUE) && have && (!active || mi.req_ready);
`else
    req_vld = (state == ISSUE) && have;
    step    = req_vld && mi.req_ready;
`endif
    // A strided mask word covers 64 elements; index items cover one each.
    pop  = step && nd && (cfg_idx || bit_sel == 6'd63 || elem_last);
    push = mi.mask_idx_valid && ((count != CNT_W'(DEPTH)) || pop);
  end

  assign mi.req_valid       = req_vld;
  assign mi.req_addr        = req_vld ? addr : '0;
  assign mi.req_elem        = req_vld ? elem : '0;
  assign mi.req_active      = req_vld && active;
  assign mi.req_last        = req_vld && elem_last;
  assign mi.mask_idx_credit = credit;
  assign o_busy             = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cfg_base   <= '0;
      cfg_stride <= '0;
      cfg_vl     <= '0;
      cfg_msk    <= 1'b0;
      cfg_idx    <= 1'b0;
      elem       <= '0;
      addr_acc   <= '0;
      credit     <= 1'b0;
    end else begin
      credit <= pop;
      if (start_ok) begin
        cfg_base   <= i_base_addr;
        cfg_stride <= i_stride;
        cfg_vl     <= i_vl;
        cfg_msk    <= i_is_masked;
        cfg_idx    <= i_is_indexed;
        elem       <= '0;
        addr_acc   <= i_base_addr;
      end else if (step) begin
        elem     <= elem + ELEM_W'(1);
        addr_acc <= addr_acc + cfg_stride;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_item[wr_ptr] <= mi.mask_idx_item;
      fifo_last[wr_ptr] <= mi.mask_idx_last_idx;
    end
  end

  a_start_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n) i_start |-> state == IDLE);
  a_last_idx:   assert property (@(posedge i_clk) disable iff (!i_reset_n) (pop && elem_last) |-> head_last);
  a_push_full:  assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                 mi.mask_idx_valid |-> ((count != CNT_W'(DEPTH)) || pop));
endmodule
